// File: rtl/sipo_rx_pkg.sv
// Shared types for the sipo_rx serial receiver.
// Build option: define SIPO_RX_PARITY_EN to append an even-parity bit to each frame.
package sipo_rx_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_rx_bitcnt.sv
// Data-bit counter for sipo_rx: counts accepted data bits, wraps after W,
// and flags the cycle in which the W-th data bit is being accepted.
module sipo_rx_bitcnt #(
    parameter int W     = 4,
    parameter int CNT_W = $clog2(W+1)
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic sclr,
    output logic last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] base;

    // sync clear applies before this cycle's increment
    always_comb begin
        base = sclr ? '0 : cnt;
        last = inc && (base == CNT_W'(W-1));
    end

    // counter state; returns to 0 on the cycle the last data bit lands
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            cnt <= '0;
        else if (inc)
            cnt <= last ? '0 : base + 1'b1;
        else if (sclr)
            cnt <= '0;
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: LSB-first bits in, W-bit words out on a
// registered valid/ready port with a sticky overrun flag.
// Build option: SIPO_RX_PARITY_EN adds a trailing even-parity bit and parity_err.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         sync,
    output logic [W-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         overrun
`ifdef SIPO_RX_PARITY_EN
    ,output logic        parity_err
`endif
);

    localparam int CNT_W = $clog2(W+1);

`ifdef SIPO_RX_PARITY_EN
    // The whole data word must sit in shreg while the parity bit arrives.
    localparam int SH_W = W;
`else
    // The last data bit is taken straight from sin, so only W-1 bits are stored.
    localparam int SH_W = W-1;
`endif

    state_t          state;
    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] shbase;
    logic [SH_W-1:0] shnext;
    logic            pbit_acc;
    logic            shift_acc;
    logic            last;
    logic            complete;
    logic [W-1:0]    word;
`ifdef SIPO_RX_PARITY_EN
    logic            perr_new;
`endif

    // classify this cycle's accepted bit and build the candidate word
    always_comb begin
        shbase = sync ? '0 : shreg;
        shnext = SH_W'({sin, shbase} >> 1);
`ifdef SIPO_RX_PARITY_EN
        pbit_acc = sin_en && (state == PARITY) && !sync;
        complete = pbit_acc;
        word     = shreg;
        perr_new = ^{shreg, sin};
`else
        pbit_acc = 1'b0;
        complete = last;
        word     = {sin, shbase};
`endif
        shift_acc = sin_en && !pbit_acc;
    end

    sipo_rx_bitcnt #(.W(W), .CNT_W(CNT_W)) u_bitcnt (
        .clk  (clk),
        .clr  (clr),
        .inc  (shift_acc),
        .sclr (sync),
        .last (last)
    );

    // frame FSM, shift register and registered output port
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            shreg      <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (shift_acc) begin
                shreg <= shnext;
`ifdef SIPO_RX_PARITY_EN
                state <= last ? PARITY : SHIFT;
`else
                state <= last ? IDLE : SHIFT;
`endif
            end else if (pbit_acc) begin
                state <= IDLE;
            end else if (sync) begin
                shreg <= '0;
                state <= IDLE;
            end

            // a completed word either loads (possibly replacing one being
            // consumed this edge) or is dropped against a full output
            if (complete) begin
                if (q_valid && !q_ready) begin
                    overrun <= 1'b1;
                end else begin
                    q       <= word;
                    q_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
                    parity_err <= perr_new;
`endif
                end
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: directed scenarios plus random traffic,
// checked against a bit-queue reference model.
module tb_sipo_rx;

    localparam int W = 4;
`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         pe;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         sin, sin_en, sync, q_ready;
    logic [W-1:0] q;
    logic         q_valid, overrun;
`ifdef SIPO_RX_PARITY_EN
    logic         parity_err;
`endif

    sipo_rx #(.W(W)) dut (
        .clk     (clk),
        .clr     (clr),
        .sin     (sin),
        .sin_en  (sin_en),
        .sync    (sync),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .overrun (overrun)
`ifdef SIPO_RX_PARITY_EN
        ,.parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit           bits[$];
    exp_t         sb[$];
    logic         mdl_full = 1'b0;
    logic         mdl_ovr  = 1'b0;
    logic [W-1:0] mdl_q    = '0;
    logic         mdl_pe   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        sb.delete();
        mdl_full = 1'b0;
        mdl_ovr  = 1'b0;
        mdl_q    = '0;
        mdl_pe   = 1'b0;
    endtask

    // one clock edge of the receiver, stated as frame rules on a bit list
    task automatic model_step();
        logic [W-1:0] d;
        logic         pe;
        bit           done;
        done = 0;
        d    = '0;
        pe   = 1'b0;
        if (sync) bits.delete();
        if (sin_en) begin
            bits.push_back(sin);
            if (bits.size() == FRAME) begin
                for (int i = 0; i < W; i++) d[i] = bits[i];
                for (int i = 0; i < FRAME; i++) pe ^= bits[i];
                bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (mdl_full && !q_ready) begin
                mdl_ovr = 1'b1;
            end else begin
                sb.push_back('{d: d, pe: pe});
                mdl_full = 1'b1;
                mdl_q    = d;
                mdl_pe   = pe;
            end
        end else if (mdl_full && q_ready) begin
            mdl_full = 1'b0;
        end
    endtask

    // one cycle: inputs held across the edge, model advanced on that edge
    task automatic cyc(input logic en, input logic b, input logic sy, input logic rdy);
        sin_en  = en;
        sin     = b;
        sync    = sy;
        q_ready = rdy;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int gap, input logic rdy,
                              input logic rdy_last, input logic pflip);
        logic b;
        for (int i = 0; i < FRAME; i++) begin
            b = (i < W) ? w[i] : ((^w) ^ pflip);
            cyc(1'b1, b, 1'b0, (i == FRAME-1) ? rdy_last : rdy);
            if (i != FRAME-1)
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    // asynchronous reset pulse away from the clock edge
    task automatic pulse_reset();
        clr = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        clr = 1'b1;
    endtask

    // monitor: compare the output port with the scoreboard every cycle
    always @(negedge clk) begin
        chk("q_valid", 32'(q_valid), 32'(mdl_full));
        chk("overrun", 32'(overrun), 32'(mdl_ovr));
        chk("q_hold", 32'(q), 32'(mdl_q));
`ifdef SIPO_RX_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(mdl_pe));
`endif
        if (q_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: q_valid=1 with q=%0h, expected no word", q);
            end else begin
                chk("sb_q", 32'(q), 32'(sb[0].d));
`ifdef SIPO_RX_PARITY_EN
                chk("sb_perr", 32'(parity_err), 32'(sb[0].pe));
`endif
                if (q_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        clr = 1'b0; sin = 1'b0; sin_en = 1'b0; sync = 1'b0; q_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b1;

        // basic word 1,0,1,1 -> D, valid for one cycle
        send_frame(4'hD, 0, 1'b1, 1'b1, 1'b0);
        chk("basic_q", 32'(q), 32'hD);
        chk("basic_valid", 32'(q_valid), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_valid_fall", 32'(q_valid), 32'h0);

        // same bits with three idle cycles between
        send_frame(4'hD, 3, 1'b1, 1'b1, 1'b0);
        chk("gap_q", 32'(q), 32'hD);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // reset in the middle of a word; next frame starts cleanly
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        pulse_reset();
        send_frame(4'h6, 0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_q", 32'(q), 32'h6);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // backpressure: second word dropped, overrun sticky
        send_frame(4'hA, 0, 1'b0, 1'b0, 1'b0);
        send_frame(4'h5, 0, 1'b0, 1'b0, 1'b0);
        chk("bp_q", 32'(q), 32'hA);
        chk("bp_ovr", 32'(overrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_valid_fall", 32'(q_valid), 32'h0);
        chk("bp_ovr_sticky", 32'(overrun), 32'h1);
        pulse_reset();

        // consume and complete on the same edge
        send_frame(4'h3, 0, 1'b0, 1'b0, 1'b0);
        send_frame(4'h9, 0, 1'b0, 1'b1, 1'b0);
        chk("sim_q", 32'(q), 32'h9);
        chk("sim_valid", 32'(q_valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // sync discards a partial word; sin on the sync cycle is bit 0
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SIPO_RX_PARITY_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
`endif
        chk("sync_q", 32'(q), 32'h9);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_RX_PARITY_EN
        send_frame(4'hD, 0, 1'b1, 1'b1, 1'b0);
        chk("par_ok", 32'(parity_err), 32'h0);
        send_frame(4'hD, 0, 1'b1, 1'b1, 1'b1);
        chk("par_bad", 32'(parity_err), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // random traffic with occasional sync and reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0)
                pulse_reset();
            else
                cyc(($urandom_range(0, 9) < 7), 1'($urandom),
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6));
        end

        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
